// File: rtl/mem_pkg.sv
// Shared types and address-map helpers for the memory router.
// The map is defined on the two most significant address bits:
//   0x -> ROM, 10 -> RAM, 11 -> memory-mapped IO.
package mem_pkg;

    typedef enum logic [1:0] {
        REG_ROM,
        REG_RAM,
        REG_IO
    } region_t;

    typedef enum logic [1:0] {
        IDLE,
        MEM_WAIT,
        IO_WAIT,
        RESP
    } rd_state_t;

    // Region tags, compared against addr[ADDR_W-1 -: 2]
    localparam logic [1:0] RAM_TAG = 2'b10;
    localparam logic [1:0] IO_TAG  = 2'b11;

    function automatic region_t decode_region(input logic [1:0] top);
        if (!top[1])
            return REG_ROM;
        else if (top == IO_TAG)
            return REG_IO;
        else
            return REG_RAM;
    endfunction

endpackage

// File: rtl/memory_router_write_stage.sv
// One-entry registered write stage.
// Ports:
//   clock, reset            clock / async active-high reset
//   wr_req_i, wr_addr_i,    incoming CPU write (always accepted)
//   wr_data_i
//   rd_req_i, rd_addr_i     current read request, for the hazard compare
//   hazard_o                a read targets the staged write address
//   wr_err_o                staged write hits ROM and is dropped
//   ram_wren_o, ram_wraddr_o, wdata_o   RAM write strobe / address / data
//   io_wen_o, io_local_o    per-channel IO write strobe and local address
module mem_write_stage
    import mem_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int N_IO   = 4,
    parameter int IO_AW  = 12,
    parameter int CH_W   = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_req_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_req_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic              hazard_o,
    output logic              wr_err_o,
    output logic              ram_wren_o,
    output logic [ADDR_W-3:0] ram_wraddr_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic [N_IO-1:0]   io_wen_o,
    output logic [IO_AW-1:0]  io_local_o
);

    logic              vld_q, vld_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    region_t           rgn;
    logic [CH_W-1:0]   ch;

    always_comb begin
        vld_d  = wr_req_i;
        addr_d = addr_q;
        data_d = data_q;
        if (wr_req_i) begin
            addr_d = wr_addr_i;
            data_d = wr_data_i;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_q  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign rgn = decode_region(addr_q[ADDR_W-1 -: 2]);
    // With a single channel there are no channel-select bits
    assign ch  = (N_IO > 1) ? addr_q[ADDR_W-3 -: CH_W] : '0;

    assign hazard_o     = vld_q && rd_req_i && (rd_addr_i == addr_q);
    assign wr_err_o     = vld_q && (rgn == REG_ROM);
    assign ram_wren_o   = vld_q && (rgn == REG_RAM);
    assign ram_wraddr_o = addr_q[ADDR_W-3:0];
    assign wdata_o      = data_q;
    assign io_local_o   = addr_q[IO_AW-1:0];

    always_comb begin
        io_wen_o = '0;
        for (int i = 0; i < N_IO; i++)
            io_wen_o[i] = vld_q && (rgn == REG_IO) && (ch == CH_W'(i));
    end

endmodule

// File: rtl/memory_router.sv
// Routes one CPU read port and one CPU write port to ROM, RAM and N_IO
// memory-mapped IO channels.
// Ports:
//   clock, reset                      clock / async active-high reset
//   rd_req/rd_addr/rd_ready           read request handshake
//   rd_valid/rd_data/rd_err           one-cycle read response (err = IO timeout)
//   wr_req/wr_addr/wr_data/wr_ready   write port (never stalls)
//   wr_err                            pulse when a ROM write is dropped
//   rom_addr/rom_q                    ROM macro (registered, MEM_LAT latency)
//   ram_rdaddr/ram_q                  RAM read side
//   ram_wraddr/ram_wdata/ram_wren     RAM write side
//   io_addr/io_wdata/io_wen/io_ren    flattened per-channel IO request buses
//   io_rdata/io_rvalid                flattened per-channel IO responses
module memory_router
    import mem_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int N_IO       = 4,
    parameter int MEM_LAT    = 1,
    parameter int IO_TIMEOUT = 15,
    parameter int IO_AW      = ADDR_W - 2 - $clog2(N_IO)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   rd_req,
    input  logic [ADDR_W-1:0]      rd_addr,
    output logic                   rd_ready,
    output logic                   rd_valid,
    output logic [DATA_W-1:0]      rd_data,
    output logic                   rd_err,
    input  logic                   wr_req,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [DATA_W-1:0]      wr_data,
    output logic                   wr_ready,
    output logic                   wr_err,
    output logic [ADDR_W-2:0]      rom_addr,
    input  logic [DATA_W-1:0]      rom_q,
    output logic [ADDR_W-3:0]      ram_rdaddr,
    output logic [ADDR_W-3:0]      ram_wraddr,
    output logic [DATA_W-1:0]      ram_wdata,
    output logic                   ram_wren,
    input  logic [DATA_W-1:0]      ram_q,
    output logic [N_IO*IO_AW-1:0]  io_addr,
    output logic [N_IO*DATA_W-1:0] io_wdata,
    output logic [N_IO-1:0]        io_wen,
    output logic [N_IO-1:0]        io_ren,
    input  logic [N_IO*DATA_W-1:0] io_rdata,
    input  logic [N_IO-1:0]        io_rvalid
);

    localparam int CH_W  = (N_IO > 1) ? $clog2(N_IO) : 1;
    localparam int TMR_W = $clog2(IO_TIMEOUT + 1);

    rd_state_t         state_q, state_d;
    region_t           rgn_q, rgn_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [ADDR_W-2:0] addr_q, addr_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    region_t           rd_rgn;
    logic [CH_W-1:0]   rd_ch;
    logic              hazard, accept;
    logic [ADDR_W-2:0] raddr;

    logic              wr_hit_ram;
    logic [ADDR_W-3:0] st_wraddr;
    logic [DATA_W-1:0] st_wdata;
    logic [N_IO-1:0]   st_io_wen;
    logic [IO_AW-1:0]  st_io_local;

    assign rd_rgn = decode_region(rd_addr[ADDR_W-1 -: 2]);
    assign rd_ch  = (N_IO > 1) ? rd_addr[ADDR_W-3 -: CH_W] : '0;
    assign accept = rd_req && rd_ready;

    mem_write_stage #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .N_IO   (N_IO),
        .IO_AW  (IO_AW),
        .CH_W   (CH_W)
    ) u_wstage (
        .clock        (clock),
        .reset        (reset),
        .wr_req_i     (wr_req),
        .wr_addr_i    (wr_addr),
        .wr_data_i    (wr_data),
        .rd_req_i     (rd_req),
        .rd_addr_i    (rd_addr),
        .hazard_o     (hazard),
        .wr_err_o     (wr_err),
        .ram_wren_o   (wr_hit_ram),
        .ram_wraddr_o (st_wraddr),
        .wdata_o      (st_wdata),
        .io_wen_o     (st_io_wen),
        .io_local_o   (st_io_local)
    );

    assign wr_ready   = 1'b1;
    assign ram_wren   = wr_hit_ram;
    assign ram_wraddr = st_wraddr;
    assign ram_wdata  = st_wdata;
    assign io_wen     = st_io_wen;

    // ---------------- state register ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rgn_q   <= REG_ROM;
            ch_q    <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            tmr_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rgn_q   <= rgn_d;
            ch_q    <= ch_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        rgn_d   = rgn_q;
        ch_d    = ch_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        tmr_d   = tmr_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    rgn_d  = rd_rgn;
                    ch_d   = rd_ch;
                    addr_d = rd_addr[ADDR_W-2:0];
                    err_d  = 1'b0;
                    if (rd_rgn == REG_IO) begin
                        state_d = IO_WAIT;
                        tmr_d   = '0;
                    end else begin
                        state_d = MEM_WAIT;
                        cnt_d   = 2'(MEM_LAT);
                    end
                end
            end
            MEM_WAIT: begin
                // The macro registered the address on the accept edge, so
                // its output is valid after MEM_LAT cycles in this state.
                if (cnt_q == 2'd1) begin
                    rdata_d = (rgn_q == REG_ROM) ? rom_q : ram_q;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            IO_WAIT: begin
                if (io_rvalid[ch_q]) begin
                    rdata_d = io_rdata[int'(ch_q)*DATA_W +: DATA_W];
                    state_d = RESP;
                end else if (tmr_q == TMR_W'(IO_TIMEOUT)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    // The read address follows the port while idle so the registered
    // macros see it on the accept edge, then holds for the transaction.
    assign raddr = (state_q == IDLE) ? rd_addr[ADDR_W-2:0] : addr_q;

    always_comb begin
        rd_ready   = !reset && (state_q == IDLE) && !hazard;
        rd_valid   = (state_q == RESP);
        rd_err     = (state_q == RESP) && err_q;
        rd_data    = rdata_q;
        rom_addr   = raddr;
        ram_rdaddr = raddr[ADDR_W-3:0];
        io_addr    = '0;
        io_wdata   = '0;
        io_ren     = '0;
        for (int i = 0; i < N_IO; i++) begin
            // A staged write owns the channel's address bus in its cycle;
            // otherwise the channel being read sees the read local address.
            if (st_io_wen[i]) begin
                io_addr[i*IO_AW +: IO_AW]   = st_io_local;
                io_wdata[i*DATA_W +: DATA_W] = st_wdata;
            end else if ((state_q == IDLE && rd_rgn == REG_IO && rd_ch == CH_W'(i)) ||
                         (state_q == IO_WAIT && ch_q == CH_W'(i))) begin
                io_addr[i*IO_AW +: IO_AW] = raddr[IO_AW-1:0];
            end
            io_ren[i] = accept && (rd_rgn == REG_IO) && (rd_ch == CH_W'(i));
        end
    end

endmodule

// File: tb/tb_memory_router.sv
// Directed bench for memory_router (defaults: 16-bit, N_IO=4, MEM_LAT=1,
// IO_TIMEOUT=15). Inputs change on the falling edge; outputs are sampled
// on the falling edge, away from the rising active edge.
module tb_memory_router;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int N_IO   = 4;
    localparam int IO_AW  = 12;

    logic                   clock;
    logic                   reset;
    logic                   rd_req;
    logic [ADDR_W-1:0]      rd_addr;
    logic                   rd_ready, rd_valid, rd_err;
    logic [DATA_W-1:0]      rd_data;
    logic                   wr_req;
    logic [ADDR_W-1:0]      wr_addr;
    logic [DATA_W-1:0]      wr_data;
    logic                   wr_ready, wr_err;
    logic [ADDR_W-2:0]      rom_addr;
    logic [DATA_W-1:0]      rom_q;
    logic [ADDR_W-3:0]      ram_rdaddr, ram_wraddr;
    logic [DATA_W-1:0]      ram_wdata, ram_q;
    logic                   ram_wren;
    logic [N_IO*IO_AW-1:0]  io_addr;
    logic [N_IO*DATA_W-1:0] io_wdata, io_rdata;
    logic [N_IO-1:0]        io_wen, io_ren, io_rvalid;

    int errors = 0;
    int checks = 0;
    int n;
    int vcount;

    memory_router dut (
        .clock(clock), .reset(reset),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready), .wr_err(wr_err),
        .rom_addr(rom_addr), .rom_q(rom_q),
        .ram_rdaddr(ram_rdaddr), .ram_wraddr(ram_wraddr),
        .ram_wdata(ram_wdata), .ram_wren(ram_wren), .ram_q(ram_q),
        .io_addr(io_addr), .io_wdata(io_wdata), .io_wen(io_wen),
        .io_ren(io_ren), .io_rdata(io_rdata), .io_rvalid(io_rvalid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Small registered RAM model (only low 8 address bits decoded)
    logic [DATA_W-1:0] mem [256];
    initial for (int i = 0; i < 256; i++) mem[i] = '0;
    always @(posedge clock) begin
        if (ram_wren) mem[ram_wraddr[7:0]] <= ram_wdata;
        ram_q <= mem[ram_rdaddr[7:0]];
    end

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called in the cycle after accept; n = cycles from accept to rd_valid
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!rd_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        reset = 1'b1; rd_req = 0; rd_addr = '0; wr_req = 0; wr_addr = '0;
        wr_data = '0; rom_q = '0; io_rdata = '0; io_rvalid = '0;
        @(negedge clock);
        #1;
        chk("reset_rd_ready", 32'(rd_ready), 0);
        chk("reset_rd_valid", 32'(rd_valid), 0);
        chk("reset_rd_data",  32'(rd_data), 0);
        chk("reset_strobes",  {25'd0, rd_err, wr_err, ram_wren, io_wen}, 0);
        chk("reset_io_ren",   32'(io_ren), 0);
        tick();
        reset = 1'b0;
        #1;
        chk("post_reset_ready", 32'(rd_ready), 1);

        // ---- ROM read 0x0012, rom_q=BEEF, latency MEM_LAT+1 = 2 ----
        @(negedge clock);
        rd_req = 1; rd_addr = 16'h0012; rom_q = 16'hBEEF;
        #1;
        chk("rom_accept_ready", 32'(rd_ready), 1);
        chk("rom_addr_idle", 32'(rom_addr), 32'h0012);
        tick();
        rd_req = 0; rd_addr = 16'h7777;
        #1;
        chk("rom_addr_held", 32'(rom_addr), 32'h0012);
        wait_valid(n);
        chk("rom_latency", n, 2);
        chk("rom_data", 32'(rd_data), 32'hBEEF);
        chk("rom_err", 32'(rd_err), 0);
        tick();
        chk("rom_valid_pulse", 32'(rd_valid), 0);

        // ---- RAM write 0x8004=1234 then read same address: hazard ----
        wr_req = 1; wr_addr = 16'h8004; wr_data = 16'h1234;
        tick();
        wr_req = 0; rd_req = 1; rd_addr = 16'h8004;
        #1;
        chk("raw_ram_wren", 32'(ram_wren), 1);
        chk("raw_ram_wraddr", 32'(ram_wraddr), 32'h0004);
        chk("raw_ram_wdata", 32'(ram_wdata), 32'h1234);
        chk("raw_hazard_stall", 32'(rd_ready), 0);
        tick();
        #1;
        chk("raw_ready_after", 32'(rd_ready), 1);
        chk("raw_wren_once", 32'(ram_wren), 0);
        tick();
        rd_req = 0;
        wait_valid(n);
        chk("raw_latency", n, 2);
        chk("raw_data", 32'(rd_data), 32'h1234);
        tick();

        // ---- Simultaneous read 0x8004 and write 0x8010 ----
        rd_req = 1; rd_addr = 16'h8004;
        wr_req = 1; wr_addr = 16'h8010; wr_data = 16'h5555;
        #1;
        chk("simul_ready", 32'(rd_ready), 1);
        tick();
        rd_req = 0; wr_req = 0;
        #1;
        chk("simul_wren", 32'(ram_wren), 1);
        chk("simul_wraddr", 32'(ram_wraddr), 32'h0010);
        wait_valid(n);
        chk("simul_data", 32'(rd_data), 32'h1234);
        tick();

        // ---- IO read 0xD003 (ch1, local 003), rvalid 3 cycles later ----
        rd_req = 1; rd_addr = 16'hD003;
        #1;
        chk("io_ren_pulse", 32'(io_ren), 32'b0010);
        chk("io_addr_ch1", 32'(io_addr[1*IO_AW +: IO_AW]), 32'h003);
        tick();
        rd_req = 0;
        // stray response on a non-selected channel must be ignored
        io_rvalid = 4'b0001; io_rdata[0 +: DATA_W] = 16'hFFFF;
        #1;
        chk("io_ren_once", 32'(io_ren), 0);
        tick();
        io_rvalid = '0;
        #1;
        chk("io_ignore_other", 32'(rd_valid), 0);
        tick();
        io_rvalid = 4'b0010; io_rdata[1*DATA_W +: DATA_W] = 16'h00A5;
        tick();
        io_rvalid = '0;
        chk("io_valid_at_4", 32'(rd_valid), 1);
        chk("io_data", 32'(rd_data), 32'h00A5);
        chk("io_err", 32'(rd_err), 0);
        tick();

        // ---- IO read 0xF000 with no response: timeout ----
        rd_req = 1; rd_addr = 16'hF000;
        tick();
        rd_req = 0;
        wait_valid(n);
        chk("to_latency", n, 17);
        chk("to_err", 32'(rd_err), 1);
        chk("to_data", 32'(rd_data), 0);
        tick();
        chk("to_ready_after", 32'(rd_ready), 1);
        rd_req = 1; rd_addr = 16'h0020; rom_q = 16'h4321;
        tick();
        rd_req = 0;
        wait_valid(n);
        chk("to_next_latency", n, 2);
        chk("to_next_data", 32'(rd_data), 32'h4321);
        chk("to_next_err", 32'(rd_err), 0);
        tick();

        // ---- ROM write dropped ----
        wr_req = 1; wr_addr = 16'h0100; wr_data = 16'hDEAD;
        tick();
        wr_req = 0;
        chk("romwr_err", 32'(wr_err), 1);
        chk("romwr_no_wren", {31'd0, ram_wren}, 0);
        chk("romwr_no_iowen", 32'(io_wen), 0);
        tick();
        chk("romwr_err_pulse", 32'(wr_err), 0);

        // ---- IO write 0xE005 = CAFE (ch2, local 005) ----
        wr_req = 1; wr_addr = 16'hE005; wr_data = 16'hCAFE;
        tick();
        wr_req = 0;
        chk("iowr_wen", 32'(io_wen), 32'b0100);
        chk("iowr_addr", 32'(io_addr[2*IO_AW +: IO_AW]), 32'h005);
        chk("iowr_data", 32'(io_wdata[2*DATA_W +: DATA_W]), 32'hCAFE);
        chk("iowr_no_ram", 32'(ram_wren), 0);
        tick();

        // ---- Reset during IO_WAIT with a staged write pending ----
        rd_req = 1; rd_addr = 16'hC010;
        tick();
        rd_req = 0; wr_req = 1; wr_addr = 16'h8020; wr_data = 16'h9999;
        tick();
        wr_req = 0;
        reset = 1;
        #1;
        chk("rst_mid_wren", 32'(ram_wren), 0);
        chk("rst_mid_ready", 32'(rd_ready), 0);
        chk("rst_mid_valid", 32'(rd_valid), 0);
        tick();
        reset = 0;
        #1;
        chk("rst_mid_ready_after", 32'(rd_ready), 1);
        vcount = 0;
        for (int i = 0; i < 20; i++) begin
            if (rd_valid) vcount++;
            tick();
        end
        chk("rst_no_valid", vcount, 0);
        rd_req = 1; rd_addr = 16'h8020;
        tick();
        rd_req = 0;
        wait_valid(n);
        chk("rst_read_latency", n, 2);
        chk("rst_write_discarded", 32'(rd_data), 0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
